// File: rtl/debounce_multi_if.sv
// debounce_multi_if
//   Button-side bundle for the N-channel debouncer.
//   data_i  : raw asynchronous button levels (driven by the board side)
//   data_o  : debounced level per channel
//   rise_o  : one-cycle pulse when data_o goes 0->1
//   fall_o  : one-cycle pulse when data_o goes 1->0
//   press_o : rise_o or auto-repeat pulse, for the game control FSM
//   master  : the side that drives the buttons and consumes the events
//   slave   : the debouncer itself
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] data_i;
  logic [CHANNELS-1:0] data_o;
  logic [CHANNELS-1:0] rise_o;
  logic [CHANNELS-1:0] fall_o;
  logic [CHANNELS-1:0] press_o;

  modport master (output data_i, input data_o, rise_o, fall_o, press_o);
  modport slave  (input data_i, output data_o, rise_o, fall_o, press_o);
endinterface

// File: rtl/debounce_multi.sv
// debounce_multi
//   N independent button debouncers: 2-FF synchroniser, stability filter,
//   registered rise/fall pulses and an optional auto-repeat press pulse.
//   clk   : clock
//   rst_n : asynchronous reset, active HIGH despite the name
//   bus   : debounce_multi_if.slave (data_i in; data_o, rise_o, fall_o,
//           press_o out)
module debounce_multi #(
  parameter int                  CHANNELS       = 4,
  parameter logic [CHANNELS-1:0] INIT_VALUE     = {CHANNELS{1'b0}},
  parameter int                  CNT_W          = 16,
  parameter logic [CNT_W-1:0]    DEBOUNCE_DELAY = 16'd10000,
  parameter int                  REPEAT_EN      = 1,
  parameter logic [CNT_W-1:0]    REPEAT_DELAY   = 16'd50000,
  parameter logic [CNT_W-1:0]    REPEAT_PERIOD  = 16'd20000
) (
  input logic             clk,
  input logic             rst_n,
  debounce_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_DELAY - 1'b1;
  localparam logic [CNT_W-1:0] RD_LAST = REPEAT_DELAY - 1'b1;
  localparam logic [CNT_W-1:0] RP_LAST = REPEAT_PERIOD - 1'b1;

  // Per-channel repeat phase: waiting for the first repeat uses REPEAT_DELAY,
  // every later one uses REPEAT_PERIOD.
  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_FIRST  = 2'd1,
    REP_PERIOD = 2'd2
  } rep_state_t;

  logic [CHANNELS-1:0] sync_p0;
  logic [CHANNELS-1:0] sync_p1;
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] press_q;
  logic [CNT_W-1:0]    cnt  [CHANNELS];
  logic [CNT_W-1:0]    rcnt [CHANNELS];
  rep_state_t          rep_q [CHANNELS];
  rep_state_t          rep_d [CHANNELS];

  logic [CHANNELS-1:0] differ;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] rep_due;
  logic [CHANNELS-1:0] rep_fire;

  // Filter decision: a new level is accepted on the DEBOUNCE_DELAY-th
  // consecutive synchronised sample that differs from the current level.
  always_comb begin
    differ = sync_p1 ^ level_q;
    accept = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      accept[k] = differ[k] && (cnt[k] == DB_LAST);
    end
  end

  // Repeat state register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int k = 0; k < CHANNELS; k++) rep_q[k] <= REP_IDLE;
    end else begin
      for (int k = 0; k < CHANNELS; k++) rep_q[k] <= rep_d[k];
    end
  end

  // Repeat next-state: a rise arms, a fall disarms, the first due pulse
  // switches to the periodic phase.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      rep_d[k] = rep_q[k];
      if (accept[k] && sync_p1[k]) begin
        rep_d[k] = (REPEAT_EN != 0) ? REP_FIRST : REP_IDLE;
      end else if (accept[k]) begin
        rep_d[k] = REP_IDLE;
      end else if (rep_due[k]) begin
        rep_d[k] = REP_PERIOD;
      end
    end
  end

  // Repeat outputs: a falling level on the same edge suppresses the pulse.
  always_comb begin
    rep_due  = '0;
    rep_fire = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      rep_due[k]  = (rep_q[k] != REP_IDLE) &&
                    (rcnt[k] == ((rep_q[k] == REP_FIRST) ? RD_LAST : RP_LAST));
      rep_fire[k] = rep_due[k] && !accept[k];
    end
  end

  // Stage p0/p1: synchroniser; then filter level, counters and event pulses
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_p0 <= INIT_VALUE;
      sync_p1 <= INIT_VALUE;
      level_q <= INIT_VALUE;
      rise_q  <= '0;
      fall_q  <= '0;
      press_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt[k]  <= '0;
        rcnt[k] <= '0;
      end
    end else begin
      sync_p0 <= bus.data_i;
      sync_p1 <= sync_p0;
      level_q <= level_q ^ accept;
      rise_q  <= accept & sync_p1;
      fall_q  <= accept & ~sync_p1;
      press_q <= (accept & sync_p1) | rep_fire;
      for (int k = 0; k < CHANNELS; k++) begin
        if (!differ[k] || accept[k]) begin
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
        // rcnt restarts on every level change and on every due repeat, so it
        // never exceeds max(REPEAT_DELAY, REPEAT_PERIOD)-1.
        if (accept[k] || rep_due[k] || (rep_q[k] == REP_IDLE)) begin
          rcnt[k] <= '0;
        end else begin
          rcnt[k] <= rcnt[k] + 1'b1;
        end
      end
    end
  end

  assign bus.data_o  = level_q;
  assign bus.rise_o  = rise_q;
  assign bus.fall_o  = fall_q;
  assign bus.press_o = press_q;

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi
//   Two debouncers side by side: A (INIT 0000, auto-repeat 10/5) and
//   B (INIT 1111, auto-repeat off), both DEBOUNCE_DELAY=4. A sliding-window
//   reference model predicts every output after every clock edge; directed
//   steps cover latency, bounce, repeat timing, fall-vs-repeat and reset.
module tb_debounce_multi;
  localparam int CH  = 4;
  localparam int DLY = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;
  localparam logic [CH-1:0] INIT_A = 4'b0000;
  localparam logic [CH-1:0] INIT_B = 4'b1111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debounce_multi_if #(.CHANNELS(CH)) bus_a ();
  debounce_multi_if #(.CHANNELS(CH)) bus_b ();

  debounce_multi #(
    .CHANNELS(CH), .INIT_VALUE(INIT_A), .CNT_W(16), .DEBOUNCE_DELAY(16'(DLY)),
    .REPEAT_EN(1), .REPEAT_DELAY(16'(RD)), .REPEAT_PERIOD(16'(RP))
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  debounce_multi #(
    .CHANNELS(CH), .INIT_VALUE(INIT_B), .CNT_W(16), .DEBOUNCE_DELAY(16'(DLY)),
    .REPEAT_EN(0), .REPEAT_DELAY(16'(RD)), .REPEAT_PERIOD(16'(RP))
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Reference model: hist[d][j] is data_i sampled j edges ago (j=0 newest),
  // so the synchronised sample used at an edge is hist[d][2].
  logic [CH-1:0] hist [2][8];
  logic [CH-1:0] m_do    [2];
  logic [CH-1:0] m_rise  [2];
  logic [CH-1:0] m_fall  [2];
  logic [CH-1:0] m_press [2];
  logic [CH-1:0] held    [2];
  int            rise_at [2][CH];
  int            edge_n;
  int            checks;
  int            errors;

  logic [CH-1:0] va, vb;
  logic [7:0]    pat;
  int found, presses, falls, late, seen_at, rises;

  function automatic logic [CH-1:0] init_of(input int d);
    return (d == 0) ? INIT_A : INIT_B;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 8; j++) hist[d][j] = init_of(d);
      m_do[d]    = init_of(d);
      m_rise[d]  = '0;
      m_fall[d]  = '0;
      m_press[d] = '0;
      held[d]    = '0;
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] din0, input logic [CH-1:0] din1);
    edge_n++;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int j = 7; j > 0; j--) hist[d][j] = hist[d][j-1];
        hist[d][0] = (d == 0) ? din0 : din1;
        m_rise[d]  = '0;
        m_fall[d]  = '0;
        m_press[d] = '0;
        for (int c = 0; c < CH; c++) begin
          bit acc;
          bit rep;
          int t;
          acc = 1'b1;
          for (int j = 2; j <= DLY + 1; j++) begin
            if (hist[d][j][c] == m_do[d][c]) acc = 1'b0;
          end
          rep = 1'b0;
          if ((d == 0) && held[d][c]) begin
            t   = edge_n - rise_at[d][c];
            rep = (t == RD) || ((t > RD) && (((t - RD) % RP) == 0));
          end
          if (acc) begin
            if (!m_do[d][c]) begin
              m_rise[d][c]  = 1'b1;
              held[d][c]    = 1'b1;
              rise_at[d][c] = edge_n;
            end else begin
              m_fall[d][c] = 1'b1;
              held[d][c]   = 1'b0;
              rep          = 1'b0;
            end
            m_do[d][c] = ~m_do[d][c];
          end
          m_press[d][c] = m_rise[d][c] | rep;
        end
      end
    end
  endtask

  task automatic chk_vec(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk_vec("a_data_o",  bus_a.data_o,  m_do[0]);
    chk_vec("a_rise_o",  bus_a.rise_o,  m_rise[0]);
    chk_vec("a_fall_o",  bus_a.fall_o,  m_fall[0]);
    chk_vec("a_press_o", bus_a.press_o, m_press[0]);
    chk_vec("b_data_o",  bus_b.data_o,  m_do[1]);
    chk_vec("b_rise_o",  bus_b.rise_o,  m_rise[1]);
    chk_vec("b_fall_o",  bus_b.fall_o,  m_fall[1]);
    chk_vec("b_press_o", bus_b.press_o, m_press[1]);
  endtask

  // Drive inputs, take one clock edge, then compare on the falling edge.
  task automatic step(input logic [CH-1:0] a, input logic [CH-1:0] b);
    bus_a.data_i = a;
    bus_b.data_i = b;
    @(posedge clk);
    model_edge(a, b);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int hold);
    #2 rst_n = 1'b1;
    #1 model_reset();
    check_all();
    repeat (hold) step(va, vb);
    rst_n = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    va = 4'b0000;
    vb = 4'b1111;
    bus_a.data_i = va;
    bus_b.data_i = vb;

    // Power-on reset with B's inputs already high
    #1 rst_n = 1'b1;
    #1 model_reset();
    check_all();
    repeat (2) step(va, vb);
    rst_n = 1'b0;
    repeat (3) step(va, vb);

    // ch0 clean 0->1: data_o at edge DLY+2, single rise pulse
    va[0] = 1'b1; seen_at = 0; rises = 0;
    for (int i = 1; i <= 12; i++) begin
      step(va, vb);
      if ((seen_at == 0) && bus_a.data_o[0]) seen_at = i;
      if (bus_a.rise_o[0]) rises++;
    end
    chk_int("ch0_rise_edge", seen_at, DLY + 2);
    chk_int("ch0_rise_pulses", rises, 1);

    // ch1 bounce 1,1,1,0,1,1,1,1 then held: the 0 restarts the count
    pat = 8'b1110_1111; seen_at = 0; rises = 0;
    for (int i = 1; i <= 16; i++) begin
      va[1] = (i <= 8) ? pat[8-i] : 1'b1;
      step(va, vb);
      if ((seen_at == 0) && bus_a.data_o[1]) seen_at = i;
      if (bus_a.rise_o[1]) rises++;
    end
    chk_int("ch1_bounce_rise_edge", seen_at, 10);
    chk_int("ch1_bounce_rise_pulses", rises, 1);

    // ch2 auto-repeat: presses at R, R+10, R+15, R+20, R+25
    va[2] = 1'b1; found = 0;
    for (int i = 0; (i < 20) && (found == 0); i++) begin
      step(va, vb);
      if (bus_a.rise_o[2]) found = 1;
    end
    chk_int("ch2_rise_found", found, 1);
    presses = bus_a.press_o[2] ? 1 : 0;
    repeat (29) begin
      step(va, vb);
      if (bus_a.press_o[2]) presses++;
    end
    chk_int("ch2_repeat_presses", presses, 5);
    va[2] = 1'b0; falls = 0; late = 0;
    repeat (20) begin
      step(va, vb);
      if ((falls != 0) && bus_a.press_o[2]) late++;
      if (bus_a.fall_o[2]) falls++;
    end
    chk_int("ch2_fall_pulses", falls, 1);
    chk_int("ch2_press_after_fall", late, 0);

    // ch3: fall lands exactly on the R+15 repeat edge; fall wins
    va[3] = 1'b1; found = 0;
    for (int i = 0; (i < 20) && (found == 0); i++) begin
      step(va, vb);
      if (bus_a.rise_o[3]) found = 1;
    end
    chk_int("ch3_rise_found", found, 1);
    repeat (9) step(va, vb);
    va[3] = 1'b0;
    repeat (6) step(va, vb);
    chk_int("ch3_collision_fall", int'(bus_a.fall_o[3]), 1);
    chk_int("ch3_collision_press", int'(bus_a.press_o[3]), 0);

    // B: drop ch3 from its held-high reset level
    vb[3] = 1'b0; seen_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(va, vb);
      if ((seen_at == 0) && bus_b.fall_o[3]) seen_at = i;
    end
    chk_int("b_ch3_fall_edge", seen_at, DLY + 2);

    // Reset mid-count on ch2 (cnt=2) while ch0/ch1 are repeating
    va[2] = 1'b1;
    repeat (4) step(va, vb);
    do_reset(2);
    seen_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(va, vb);
      if ((seen_at == 0) && bus_a.data_o[2]) seen_at = i;
    end
    chk_int("ch2_after_reset_edge", seen_at, DLY + 2);

    // Randomised bouncing on both debouncers, with one reset in the middle
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) va[$urandom_range(CH-1)] ^= 1'b1;
      if ($urandom_range(3) == 0) vb[$urandom_range(CH-1)] ^= 1'b1;
      if (i == 150) do_reset(2);
      step(va, vb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
